// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WAIT_CNT_W = 4;

  localparam logic SEL_ALU = 1'b0;
  localparam logic SEL_MEM = 1'b1;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } grant_e;

  // Saturating increment: stops at lim instead of wrapping.
  function automatic logic [WAIT_CNT_W-1:0] sat_inc(
    input logic [WAIT_CNT_W-1:0] val,
    input logic [WAIT_CNT_W-1:0] lim
  );
    logic [WAIT_CNT_W-1:0] res;
    if (val >= lim) begin
      res = lim;
    end else begin
      res = val + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles the ALU pipe was refused the write port.
// at_max is registered and tells the grant logic the ALU must win next conflict.
module wb_starve_ctr
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic clear,
  output logic at_max
);

  localparam logic [WAIT_CNT_W-1:0] MAX_CNT = 4'(MAX_WAIT);

  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  r_at_max;
  logic [WAIT_CNT_W-1:0] w_next_cnt;

  // Next count: clear wins over a loss, losses saturate at MAX_CNT.
  always_comb begin
    w_next_cnt = r_wait_cnt;
    if (clear) begin
      w_next_cnt = 4'd0;
    end else if (waiting) begin
      w_next_cnt = sat_inc(r_wait_cnt, MAX_CNT);
    end else begin
      w_next_cnt = r_wait_cnt;
    end
  end

  // Counter and registered saturation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
      r_at_max   <= 1'b0;
    end else begin
      r_wait_cnt <= w_next_cnt;
      r_at_max   <= (w_next_cnt == MAX_CNT);
    end
  end

  assign at_max = r_at_max;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU pipe and
// the load pipe. Loads win conflicts unless the ALU has lost MAX_WAIT times
// in a row. Writes to r0 are accepted but never enabled.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int MAX_WAIT = 3,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_sel,
  output logic [PERF_W-1:0] conflict_cnt
);

  function automatic logic is_r0(input logic [ADDR_W-1:0] rd);
    return (rd == ADDR_W'(REG_ZERO));
  endfunction

  grant_e              w_grant;
  logic                w_at_max;
  logic                w_alu_ready;
  logic                w_mem_ready;
  logic                w_waiting;
  logic                w_clear;

  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_wr_sel;
  logic [PERF_W-1:0]   r_conflict_cnt;

  wb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk     (clk),
    .rst     (rst),
    .waiting (w_waiting),
    .clear   (w_clear),
    .at_max  (w_at_max)
  );

  // Grant decision from the current valids and the starvation state only.
  always_comb begin
    w_grant = GNT_NONE;
    if (rst) begin
      w_grant = GNT_NONE;
    end else begin
      case ({alu_valid, mem_valid})
        2'b10:   w_grant = GNT_ALU;
        2'b01:   w_grant = GNT_MEM;
        2'b11:   w_grant = w_at_max ? GNT_ALU : GNT_MEM;
        default: w_grant = GNT_NONE;
      endcase
    end
  end

  assign w_alu_ready = (w_grant == GNT_ALU);
  assign w_mem_ready = (w_grant == GNT_MEM);
  // ALU lost this cycle / ALU is either served or not asking.
  assign w_waiting   = alu_valid && !w_alu_ready;
  assign w_clear     = !alu_valid || w_alu_ready;

  assign alu_ready = w_alu_ready;
  assign mem_ready = w_mem_ready;

  // Write-port register: load the granted request, otherwise just drop wr_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_sel  <= SEL_ALU;
    end else begin
      case (w_grant)
        GNT_ALU: begin
          r_wr_en   <= !is_r0(alu_rd);
          r_wr_addr <= alu_rd;
          r_wr_data <= alu_data;
          r_wr_sel  <= SEL_ALU;
        end
        GNT_MEM: begin
          r_wr_en   <= !is_r0(mem_rd);
          r_wr_addr <= mem_rd;
          r_wr_data <= mem_data;
          r_wr_sel  <= SEL_MEM;
        end
        default: begin
          r_wr_en   <= 1'b0;
        end
      endcase
    end
  end

  // Performance counter of cycles with both requesters asking; wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (alu_valid && mem_valid) begin
      r_conflict_cnt <= r_conflict_cnt + PERF_W'(1);
    end else begin
      r_conflict_cnt <= r_conflict_cnt;
    end
  end

  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign wr_sel       = r_wr_sel;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed vectors push expected
// handshake and write-port values tagged with the cycle they must appear in;
// a monitor samples on the falling edge and compares.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_sel;
  logic [15:0] conflict_cnt;

  regfile_wb_arbiter #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .MAX_WAIT (3),
    .PERF_W   (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_sel       (wr_sel),
    .conflict_cnt (conflict_cnt)
  );

  typedef struct {
    int   cyc;
    logic ar;
    logic mr;
  } rdy_t;

  typedef struct {
    int          cyc;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        sel;
    logic [15:0] cnt;
  } wr_t;

  rdy_t rdy_q[$];
  wr_t  wr_q[$];
  int   cyc     = 0;
  int   n_vec   = 0;
  int   n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: one sample per falling edge, compare anything due this cycle.
  initial begin
    rdy_t r;
    wr_t  w;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      while (rdy_q.size() > 0 && rdy_q[0].cyc <= cyc) begin
        r = rdy_q.pop_front();
        chk("alu_ready", 32'(alu_ready), 32'(r.ar));
        chk("mem_ready", 32'(mem_ready), 32'(r.mr));
      end
      while (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
        w = wr_q.pop_front();
        chk("wr_en",        32'(wr_en),        32'(w.en));
        chk("wr_addr",      32'(wr_addr),      32'(w.addr));
        chk("wr_data",      wr_data,           w.data);
        chk("wr_sel",       32'(wr_sel),       32'(w.sel));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(w.cnt));
      end
    end
  end

  // Drive one cycle of inputs and queue its hand-computed results:
  // readies this cycle, write port and conflict count after the next edge.
  task automatic vec(
    input logic r,
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic mv, input logic [4:0] mrd, input logic [31:0] md,
    input logic ear, input logic emr,
    input logic een, input logic [4:0] eaddr, input logic [31:0] edata,
    input logic esel, input logic [15:0] ecnt
  );
    rdy_t re;
    wr_t  we;
    @(posedge clk);
    #1;
    rst       = r;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    re.cyc = cyc + 1;
    re.ar  = ear;
    re.mr  = emr;
    rdy_q.push_back(re);
    we.cyc  = cyc + 2;
    we.en   = een;
    we.addr = eaddr;
    we.data = edata;
    we.sel  = esel;
    we.cnt  = ecnt;
    wr_q.push_back(we);
  endtask

  initial begin
    rst       = 1'b1;
    alu_valid = 1'b0;
    alu_rd    = 5'd0;
    alu_data  = 32'd0;
    mem_valid = 1'b0;
    mem_rd    = 5'd0;
    mem_data  = 32'd0;

    //    rst   av    ard    alu_data       mv    mrd    mem_data       ar    mr    en    addr   data           sel   cnt
    // reset held two cycles with both requesters valid
    vec(1'b1, 1'b1, 5'd5,  32'h0000_0001, 1'b1, 5'd7,  32'h0000_0002, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 16'd0);
    vec(1'b1, 1'b1, 5'd5,  32'h0000_0001, 1'b1, 5'd7,  32'h0000_0002, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 16'd0);
    // single ALU request
    vec(1'b0, 1'b1, 5'd5,  32'hA5A5_A5A5, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b1, 5'd5,  32'hA5A5_A5A5, 1'b0, 16'd0);
    // contention: MEM, MEM, MEM, ALU, MEM, MEM, MEM, ALU
    vec(1'b0, 1'b1, 5'd9,  32'h9999_0009, 1'b1, 5'd7,  32'h7777_0001, 1'b0, 1'b1, 1'b1, 5'd7,  32'h7777_0001, 1'b1, 16'd1);
    vec(1'b0, 1'b1, 5'd9,  32'h9999_0009, 1'b1, 5'd7,  32'h7777_0002, 1'b0, 1'b1, 1'b1, 5'd7,  32'h7777_0002, 1'b1, 16'd2);
    vec(1'b0, 1'b1, 5'd9,  32'h9999_0009, 1'b1, 5'd7,  32'h7777_0003, 1'b0, 1'b1, 1'b1, 5'd7,  32'h7777_0003, 1'b1, 16'd3);
    vec(1'b0, 1'b1, 5'd9,  32'h9999_0009, 1'b1, 5'd7,  32'h7777_0004, 1'b1, 1'b0, 1'b1, 5'd9,  32'h9999_0009, 1'b0, 16'd4);
    vec(1'b0, 1'b1, 5'd9,  32'h9999_000A, 1'b1, 5'd7,  32'h7777_0004, 1'b0, 1'b1, 1'b1, 5'd7,  32'h7777_0004, 1'b1, 16'd5);
    vec(1'b0, 1'b1, 5'd9,  32'h9999_000A, 1'b1, 5'd7,  32'h7777_0005, 1'b0, 1'b1, 1'b1, 5'd7,  32'h7777_0005, 1'b1, 16'd6);
    vec(1'b0, 1'b1, 5'd9,  32'h9999_000A, 1'b1, 5'd7,  32'h7777_0006, 1'b0, 1'b1, 1'b1, 5'd7,  32'h7777_0006, 1'b1, 16'd7);
    vec(1'b0, 1'b1, 5'd9,  32'h9999_000A, 1'b1, 5'd7,  32'h7777_0007, 1'b1, 1'b0, 1'b1, 5'd9,  32'h9999_000A, 1'b0, 16'd8);
    // pending load drains alone
    vec(1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd7,  32'h7777_0007, 1'b0, 1'b1, 1'b1, 5'd7,  32'h7777_0007, 1'b1, 16'd8);
    // load to r0: accepted, no write enable
    vec(1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd0,  32'hFFFF_FFFF, 1'b1, 16'd8);
    // write rd=3, then idle holds address/data/select
    vec(1'b0, 1'b1, 5'd3,  32'h0000_0033, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b1, 5'd3,  32'h0000_0033, 1'b0, 16'd8);
    vec(1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd3,  32'h0000_0033, 1'b0, 16'd8);
    vec(1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd3,  32'h0000_0033, 1'b0, 16'd8);
    // ALU to r0
    vec(1'b0, 1'b1, 5'd0,  32'h1234_5678, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0,  32'h1234_5678, 1'b0, 16'd8);
    // build wait count to 2, then reset mid-stall
    vec(1'b0, 1'b1, 5'd9,  32'hAAAA_0001, 1'b1, 5'd7,  32'hBBBB_0001, 1'b0, 1'b1, 1'b1, 5'd7,  32'hBBBB_0001, 1'b1, 16'd9);
    vec(1'b0, 1'b1, 5'd9,  32'hAAAA_0001, 1'b1, 5'd7,  32'hBBBB_0002, 1'b0, 1'b1, 1'b1, 5'd7,  32'hBBBB_0002, 1'b1, 16'd10);
    vec(1'b1, 1'b1, 5'd9,  32'hAAAA_0001, 1'b1, 5'd7,  32'hBBBB_0003, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 16'd0);
    // after release MEM wins three conflicts again, then ALU
    vec(1'b0, 1'b1, 5'd9,  32'hAAAA_0001, 1'b1, 5'd7,  32'hBBBB_0003, 1'b0, 1'b1, 1'b1, 5'd7,  32'hBBBB_0003, 1'b1, 16'd1);
    vec(1'b0, 1'b1, 5'd9,  32'hAAAA_0001, 1'b1, 5'd7,  32'hBBBB_0004, 1'b0, 1'b1, 1'b1, 5'd7,  32'hBBBB_0004, 1'b1, 16'd2);
    vec(1'b0, 1'b1, 5'd9,  32'hAAAA_0001, 1'b1, 5'd7,  32'hBBBB_0005, 1'b0, 1'b1, 1'b1, 5'd7,  32'hBBBB_0005, 1'b1, 16'd3);
    vec(1'b0, 1'b1, 5'd9,  32'hAAAA_0001, 1'b1, 5'd7,  32'hBBBB_0006, 1'b1, 1'b0, 1'b1, 5'd9,  32'hAAAA_0001, 1'b0, 16'd4);
    // same rd on both: MEM first, ALU next cycle
    vec(1'b0, 1'b1, 5'd12, 32'hC0C0_0001, 1'b1, 5'd12, 32'hD0D0_0001, 1'b0, 1'b1, 1'b1, 5'd12, 32'hD0D0_0001, 1'b1, 16'd5);
    vec(1'b0, 1'b1, 5'd12, 32'hC0C0_0001, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b1, 5'd12, 32'hC0C0_0001, 1'b0, 16'd5);
    vec(1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd12, 32'hC0C0_0001, 1'b0, 16'd5);

    // let the monitor drain, bounded
    for (int i = 0; i < 10; i++) begin
      if (rdy_q.size() != 0 || wr_q.size() != 0) begin
        @(negedge clk);
        #1;
      end
    end
    if (rdy_q.size() != 0 || wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d ready and %0d write entries left, expected 0",
               rdy_q.size(), wr_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
